// File: rtl/riscv_pkg.sv
// Shared core widths and types for the RV32 pipeline.
// Decode and writeback import these so operand widths stay in step.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/riscv_register_file.sv
// RV32 integer register file: x0 hardwired to zero, two combinational
// read ports with write-through bypass, one synchronous write port.
module riscv_register_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_address,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_address_1,
    output logic [DATA_WIDTH-1:0] o_read_data_1,
    input  logic [ADDR_WIDTH-1:0] i_read_address_2,
    output logic [DATA_WIDTH-1:0] o_read_data_2
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [1:NREG-1];
    logic                  w_wr_live;
    logic [DATA_WIDTH-1:0] w_stored_1;
    logic [DATA_WIDTH-1:0] w_stored_2;

    assign w_wr_live = i_write_enable && (i_write_address != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_write_address] <= i_write_data;
        end
    end

    // x0 has no storage, so only index the array for nonzero addresses
    always_comb begin
        w_stored_1 = '0;
        w_stored_2 = '0;
        if (i_read_address_1 != '0) begin
            w_stored_1 = r_regs[i_read_address_1];
        end
        if (i_read_address_2 != '0) begin
            w_stored_2 = r_regs[i_read_address_2];
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (addr == '0) begin
            return '0;
        end else if (w_wr_live && (addr == i_write_address)) begin
            return i_write_data;
        end else begin
            return stored;
        end
    endfunction

    assign o_read_data_1 = read_mux(i_read_address_1, w_stored_1);
    assign o_read_data_2 = read_mux(i_read_address_2, w_stored_2);

endmodule

// File: tb/tb_riscv_register_file.sv
// Directed-vector bench for riscv_register_file.
// Inputs change on the falling edge; outputs are sampled mid-cycle.
module tb_riscv_register_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic [4:0]  ra2;
    logic [31:0] rd2;

    int n_cmp;
    int n_err;

    riscv_register_file dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_write_enable   (we),
        .i_write_address  (wa),
        .i_write_data     (wd),
        .i_read_address_1 (ra1),
        .o_read_data_1    (rd1),
        .i_read_address_2 (ra2),
        .o_read_data_2    (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        @(negedge clk);
        we = 1'b0;
        wd = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        we = 1'b0;
        wa = '0;
        wd = '0;
        ra1 = 5'd1;
        ra2 = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            $display("FAIL reset_rd1: got %h want %h", rd1, 32'h0);
            n_err++;
        end
        n_cmp++;
        if (rd2 !== 32'h0) begin
            $display("FAIL reset_rd2: got %h want %h", rd2, 32'h0);
            n_err++;
        end
        // a write pending across deassertion lands on the first edge
        @(negedge clk);
        we = 1'b1;
        wa = 5'd7;
        wd = 32'h0000_7777;
        #2 rst_n = 1'b1;
        @(negedge clk);
        we = 1'b0;
        ra1 = 5'd7;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0000_7777) begin
            $display("FAIL deassert_write: got %h want %h", rd1, 32'h0000_7777);
            n_err++;
        end
    endtask

    task automatic test_basic_write;
        write_reg(5'd1, 32'h0000_00AA);
        write_reg(5'd2, 32'h0000_00AB);
        write_reg(5'd31, 32'h0000_0042);
        ra1 = 5'd1;
        ra2 = 5'd2;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0000_00AA) begin
            $display("FAIL rd_x1: got %h want %h", rd1, 32'h0000_00AA);
            n_err++;
        end
        n_cmp++;
        if (rd2 !== 32'h0000_00AB) begin
            $display("FAIL rd_x2: got %h want %h", rd2, 32'h0000_00AB);
            n_err++;
        end
        ra1 = 5'd31;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0000_0042) begin
            $display("FAIL rd_x31: got %h want %h", rd1, 32'h0000_0042);
            n_err++;
        end
    endtask

    task automatic test_x0;
        ra1 = 5'd0;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            $display("FAIL rd_x0: got %h want %h", rd1, 32'h0);
            n_err++;
        end
        @(negedge clk);
        we = 1'b1;
        wa = 5'd0;
        wd = 32'h0000_0123;
        ra2 = 5'd0;
        #1;
        n_cmp++;
        if (rd2 !== 32'h0) begin
            $display("FAIL x0_no_bypass: got %h want %h", rd2, 32'h0);
            n_err++;
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            $display("FAIL x0_after_write: got %h want %h", rd1, 32'h0);
            n_err++;
        end
    endtask

    task automatic test_overwrite;
        write_reg(5'd1, 32'h0000_00FF);
        ra1 = 5'd1;
        ra2 = 5'd2;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0000_00FF) begin
            $display("FAIL overwrite_x1: got %h want %h", rd1, 32'h0000_00FF);
            n_err++;
        end
        n_cmp++;
        if (rd2 !== 32'h0000_00AB) begin
            $display("FAIL x2_untouched: got %h want %h", rd2, 32'h0000_00AB);
            n_err++;
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        we = 1'b1;
        wa = 5'd5;
        wd = 32'hDEAD_BEEF;
        ra1 = 5'd5;
        ra2 = 5'd5;
        #1;
        n_cmp++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            $display("FAIL bypass_rd1: got %h want %h", rd1, 32'hDEAD_BEEF);
            n_err++;
        end
        n_cmp++;
        if (rd2 !== 32'hDEAD_BEEF) begin
            $display("FAIL bypass_rd2: got %h want %h", rd2, 32'hDEAD_BEEF);
            n_err++;
        end
        ra2 = 5'd1;
        #1;
        n_cmp++;
        if (rd2 !== 32'h0000_00FF) begin
            $display("FAIL bypass_other_port: got %h want %h", rd2, 32'h0000_00FF);
            n_err++;
        end
        @(negedge clk);
        we = 1'b0;
        wd = '0;
        ra2 = 5'd5;
        #1;
        n_cmp++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            $display("FAIL stored_rd1: got %h want %h", rd1, 32'hDEAD_BEEF);
            n_err++;
        end
        n_cmp++;
        if (rd2 !== 32'hDEAD_BEEF) begin
            $display("FAIL stored_rd2: got %h want %h", rd2, 32'hDEAD_BEEF);
            n_err++;
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0101);
        end
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            v = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            n_cmp++;
            if (rd1 !== v) begin
                $display("FAIL load_x%0d: got %h want %h", i, rd1, v);
                n_err++;
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #0.1;
            n_cmp++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                $display("FAIL async_clear_%0d: got %h/%h want 0", i, rd1, rd2);
                n_err++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_we_low;
        @(negedge clk);
        we = 1'b0;
        wa = 5'd3;
        wd = 32'h0000_0055;
        ra1 = 5'd3;
        #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            $display("FAIL we0_no_bypass: got %h want %h", rd1, 32'h0);
            n_err++;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            $display("FAIL we0_no_write: got %h want %h", rd1, 32'h0);
            n_err++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_write();
        test_x0();
        test_overwrite();
        test_bypass();
        test_async_reset();
        test_we_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
